// File: rtl/step_debug_pkg.sv
// Shared types and constants for the step/debug controller: step FSM states,
// seven-segment glyph constants and the hex-to-segment decoder.
package step_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } step_state_e;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TAG_I = 7'b1111001;
  localparam logic [6:0] SEG_TAG_A = 7'b0001000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer and a
// one-cycle press pulse that is only armed after a debounced release.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [DB_W-1:0] arm_cnt_q, arm_cnt_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;

  // NOTE: every register here updates with <= so all flops sample the
  // pre-edge values together, exactly like the hardware.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: each always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;

    if (sync2_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        press_d  = armed_q && !sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A button held through reset must first be seen released for a full
    // debounce window before any press is reported.
    if (!armed_q) begin
      if (!sync2_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == DB_LAST) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/step_debug_ctrl.sv
// Board-side step/debug controller for the single-cycle RISC-V core: step
// button / free-run stepping and a six-digit seven-segment debug display.
module step_debug_ctrl
  import step_debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_step_n,
  input  logic             key_page_n,
  input  logic             sw_run,
  input  logic             sw_src,
  input  logic [31:0]      inst_in,
  input  logic [31:0]      alures_in,
  output logic             cpu_step,
  output logic [CNT_W-1:0] step_count,
  output logic             page_hi,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5
);

  localparam int RUN_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

  logic step_level, step_press;
  logic page_press, page_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (key_step_n),
    .level_o (step_level),
    .press_o (step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (key_page_n),
    .level_o (page_level_unused),
    .press_o (page_press)
  );

  step_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] count_q;
  logic             page_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sw_run) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: state_d = sw_run ? ST_RUN : ST_HOLD;
      ST_HOLD: begin
        if (step_level) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!sw_run) begin
          state_d = ST_IDLE;
        end else if (run_cnt_q == RUN_LAST) begin
          state_d = ST_PULSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded straight from the state register, so the pulse is glitch-free
  // and disappears the instant reset asserts.
  always_comb begin
    cpu_step = (state_q == ST_PULSE);
  end

  // The run counter only advances while staying in RUN; any entry into RUN
  // (from IDLE or after a pulse) therefore starts from zero.
  always_comb begin
    run_cnt_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt_q <= '0;
      count_q   <= '0;
      page_q    <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      if (state_q == ST_PULSE) begin
        count_q <= count_q + 1'b1;
      end
      if (page_press) begin
        page_q <= ~page_q;
      end
    end
  end

  assign step_count = count_q;
  assign page_hi    = page_q;

  logic [31:0]     disp_word;
  logic [5:0][6:0] hex_d, hex_q;

  always_comb begin
    disp_word = sw_src ? alures_in : inst_in;
    hex_d     = {6{SEG_BLANK}};
    if (!page_q) begin
      for (int i = 0; i < 6; i++) begin
        hex_d[i] = hex_to_seg(disp_word[4*i +: 4]);
      end
    end else begin
      hex_d[0] = hex_to_seg(disp_word[27:24]);
      hex_d[1] = hex_to_seg(disp_word[31:28]);
      hex_d[5] = sw_src ? SEG_TAG_A : SEG_TAG_I;
    end
  end

  // NOTE: the digit registers are plain flops, not a RAM, so they take the
  // async reset and come up blank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q <= {6{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_step_debug_ctrl.sv
// Self-checking bench for step_debug_ctrl: cycle-by-cycle comparison against a
// behavioural model plus directed literal expectations for each scenario.
module tb_step_debug_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_step_n, key_page_n, sw_run, sw_src;
  logic [31:0]   inst_in, alures_in;
  logic          cpu_step;
  logic [CW-1:0] step_count;
  logic          page_hi;
  logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;

  always #5 clk = ~clk;

  step_debug_ctrl #(.DEBOUNCE_CYCLES(N), .RUN_DIV(RD), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_step_n (key_step_n),
    .key_page_n (key_page_n),
    .sw_run     (sw_run),
    .sw_src     (sw_src),
    .inst_in    (inst_in),
    .alures_in  (alures_in),
    .cpu_step   (cpu_step),
    .step_count (step_count),
    .page_hi    (page_hi),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic logic [5:0][6:0] exp_display(input logic [31:0] w, input logic pg,
                                                  input logic src);
    logic [5:0][6:0] d;
    for (int k = 0; k < 6; k++) d[k] = pg ? 7'h7F : glyph(w[4*k +: 4]);
    if (pg) begin
      d[0] = glyph(w[27:24]);
      d[1] = glyph(w[31:28]);
      d[5] = src ? 7'b0001000 : 7'b1111001;
    end
    return d;
  endfunction

  // Button seen through the synchronizer: the level flips once the last N
  // samples all disagree with it; presses count only after N released samples.
  typedef struct packed {
    logic [N-1:0] hist;
    logic [7:0]   seen;
    logic         lvl;
    logic         press;
    logic         armed;
  } db_t;

  localparam db_t DB_RST = '{hist: '1, seen: 8'd0, lvl: 1'b1, press: 1'b0, armed: 1'b0};

  function automatic db_t db_next(input db_t cur, input logic sample);
    db_t          nx;
    logic [N-1:0] win;
    nx       = cur;
    win      = {cur.hist[N-2:0], sample};
    nx.hist  = win;
    nx.press = 1'b0;
    if (cur.seen < 8'(N)) nx.seen = cur.seen + 8'd1;
    if (cur.seen >= 8'(N - 1)) begin
      if (win == {N{~cur.lvl}}) begin
        nx.lvl   = ~cur.lvl;
        nx.press = cur.lvl & cur.armed;
      end
      if (win == {N{1'b1}}) nx.armed = 1'b1;
    end
    return nx;
  endfunction

  logic            ms1_step, ms2_step, ms1_page, ms2_page;
  db_t             m_step, m_pagebtn;
  logic            m_pulse, m_wait_rel, m_page;
  int              m_timer;
  logic [CW-1:0]   m_count;
  logic [5:0][6:0] m_hex;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms1_step <= 1'b1; ms2_step <= 1'b1; ms1_page <= 1'b1; ms2_page <= 1'b1;
      m_step <= DB_RST; m_pagebtn <= DB_RST;
      m_pulse <= 1'b0; m_wait_rel <= 1'b0; m_timer <= -1; m_count <= '0;
      m_page <= 1'b0; m_hex <= {6{7'h7F}};
    end else begin
      ms1_step  <= key_step_n; ms2_step <= ms1_step;
      ms1_page  <= key_page_n; ms2_page <= ms1_page;
      m_step    <= db_next(m_step, ms2_step);
      m_pagebtn <= db_next(m_pagebtn, ms2_page);
      m_page    <= m_page ^ m_pagebtn.press;
      m_hex     <= exp_display(sw_src ? alures_in : inst_in, m_page, sw_src);
      if (m_pulse) begin
        m_count <= m_count + 1'b1;
        m_pulse <= 1'b0;
        if (sw_run) m_timer <= 0;
        else m_wait_rel <= 1'b1;
      end else if (m_wait_rel) begin
        if (m_step.lvl) m_wait_rel <= 1'b0;
      end else if (m_timer >= 0) begin
        if (!sw_run) m_timer <= -1;
        else if (m_timer == RD - 1) begin
          m_pulse <= 1'b1;
          m_timer <= -1;
        end else m_timer <= m_timer + 1;
      end else if (sw_run) begin
        m_timer <= 0;
      end else if (m_step.press) begin
        m_pulse <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cpu_step", 32'(cpu_step), 32'(m_pulse));
    check("step_count", 32'(step_count), 32'(m_count));
    check("page_hi", 32'(page_hi), 32'(m_page));
    check("hex0", 32'(hex0), 32'(m_hex[0]));
    check("hex1", 32'(hex1), 32'(m_hex[1]));
    check("hex2", 32'(hex2), 32'(m_hex[2]));
    check("hex3", 32'(hex3), 32'(m_hex[3]));
    check("hex4", 32'(hex4), 32'(m_hex[4]));
    check("hex5", 32'(hex5), 32'(m_hex[5]));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n, output int pulses, output int first, output int last);
    pulses = 0; first = -1; last = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (cpu_step === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
  endtask

  int pulses, first, last, base;

  initial begin
    reset = 1'b0; key_step_n = 1'b1; key_page_n = 1'b1; sw_run = 1'b0; sw_src = 1'b0;
    inst_in = 32'h0; alures_in = 32'h0;
    tick(3);
    reset = 1'b1;
    tick(10);

    // 1: manual step
    key_step_n = 1'b0;
    watch(20, pulses, first, last);
    check("t1_pulses_held", 32'(pulses), 32'd1);
    check("t1_pulse_latency", 32'(first), 32'd7);
    key_step_n = 1'b1;
    watch(20, pulses, first, last);
    check("t1_pulses_release", 32'(pulses), 32'd0);
    check("t1_count", 32'(step_count), 32'd1);

    // 2: bounce rejection
    for (int i = 0; i < 8; i++) begin
      key_step_n = i[0];
      tick(2);
    end
    key_step_n = 1'b1;
    watch(10, pulses, first, last);
    check("t2_count", 32'(step_count), 32'd1);

    // 3: run mode, then drop mid-count
    base   = int'(step_count);
    sw_run = 1'b1;
    watch(40, pulses, first, last);
    check("t3_pulses", 32'(pulses), 32'd4);
    check("t3_first", 32'(first), 32'd9);
    check("t3_span", 32'(last - first), 32'd27);
    check("t3_count_delta", 32'(int'(step_count) - base), 32'd4);
    sw_run = 1'b0;
    watch(12, pulses, first, last);
    check("t3_no_extra", 32'(pulses), 32'd0);
    check("t3_count_hold", 32'(step_count), 32'd5);

    // 4: low page, instruction source
    inst_in = 32'h00A3_0313; sw_src = 1'b0;
    tick(1);
    check("t4_hex5", 32'(hex5), 32'h08);
    check("t4_hex4", 32'(hex4), 32'h30);
    check("t4_hex3", 32'(hex3), 32'h40);
    check("t4_hex2", 32'(hex2), 32'h30);
    check("t4_hex1", 32'(hex1), 32'h79);
    check("t4_hex0", 32'(hex0), 32'h30);

    // 5: high page, ALU source
    sw_src = 1'b1; alures_in = 32'hDEAD_BEEF;
    key_page_n = 1'b0; tick(10);
    key_page_n = 1'b1; tick(10);
    check("t5_page_hi", 32'(page_hi), 32'd1);
    check("t5_hex1", 32'(hex1), 32'h21);
    check("t5_hex0", 32'(hex0), 32'h06);
    check("t5_hex5", 32'(hex5), 32'h08);
    check("t5_hex4", 32'(hex4), 32'h7F);
    check("t5_hex3", 32'(hex3), 32'h7F);
    check("t5_hex2", 32'(hex2), 32'h7F);

    // 6: reset during a pulse, button held through release
    key_step_n = 1'b0;
    first = -1;
    for (int i = 1; i <= 12 && first < 0; i++) begin
      @(negedge clk);
      if (cpu_step === 1'b1) first = i;
    end
    check("t6_pulse_seen", 32'(first), 32'd7);
    check("t6_count_in_pulse", 32'(step_count), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("t6_cpu_step", 32'(cpu_step), 32'd0);
    check("t6_count", 32'(step_count), 32'd0);
    check("t6_page", 32'(page_hi), 32'd0);
    check("t6_hex", {hex5, hex4, hex3, hex2}, {4{7'h7F}});
    check("t6_hex_lo", 32'({hex1, hex0}), 32'h3FFF);
    tick(2);
    reset = 1'b1;
    watch(20, pulses, first, last);
    check("t6_held_no_step", 32'(pulses), 32'd0);
    check("t6_held_count", 32'(step_count), 32'd0);
    key_step_n = 1'b1; tick(12);
    key_step_n = 1'b0;
    watch(15, pulses, first, last);
    check("t6_rearm_pulses", 32'(pulses), 32'd1);
    check("t6_rearm_count", 32'(step_count), 32'd1);
    key_step_n = 1'b1; tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
